ascon_aead_data_engine: RTL and testbench
=========================================

// Module: ascon_aead_data_engine
// PURPOSE
//  Streaming AD + plaintext/ciphertext absorb engine for Ascon AEAD; sits between init and finalization.
//  Loaded with the post-init 320-bit state; returns the pre-finalization state.
//  Generalises the single-cycle 128-bit p8 stage: parametrised rate and rounds, with an iterated unrolled permutation.
//  Adds a valid/ready stream, automatic padding (incl. extra pad block), AD phase and domain separation.
// PARAMETERS
//  RATE_BITS  128  block width: 64 (Ascon-128) or 128 (Ascon-128a)
//  ROUNDS_B   8    rounds of p_b between blocks (6 or 8)
//  UNROLL     2    rounds per clock; must divide ROUNDS_B (else err tied high)
// PORTS
//  clk        in   1          clock
//  rst_n      in   1          async active-low reset
//  start      in   1          pulse: load state_i, enter ABSORB (aborts any job in flight)
//  mode       in   1          0 encrypt, 1 decrypt; sampled at start
//  state_i    in   320        {x0,x1,x2,x3,x4}, x0 in [319:256]
//  in_valid   in   1          input beat valid
//  in_ready   out  1          input beat accepted when in_valid&in_ready
//  in_type    in   1          0 AD, 1 message
//  in_data    in   RATE_BITS  byte i = in_data[8i+7:8i]; x0 = bytes 0..7, x1 = bytes 8..15
//  in_bytes   in   $clog2(RATE_BITS/8)+1  valid bytes, 0..RATE_BITS/8
//  in_last    in   1          last beat of the current in_type phase
//  out_valid  out  1          output beat valid (message beats only)
//  out_ready  in   1          output accepted
//  out_data   out  RATE_BITS  CT (enc) or PT (dec); bytes >= out_bytes forced 0
//  out_bytes  out  $clog2(RATE_BITS/8)+1  copy of in_bytes of the source beat
//  done       out  1          1-cycle pulse: state_o valid
//  state_o    out  320        state after last message beat (held until next start)
//  err        out  1          sticky protocol error; cleared by start
// BEHAVIOUR
//  Reset: in_ready, out_valid, done, err = 0; out_data, out_bytes, state_o, state regs = 0; FSM IDLE.
//  FSM: IDLE -start-> ABSORB; ABSORB -beat needing perm-> PERM; PERM -count done-> ABSORB | PADBLK | FIN;
//       PADBLK (absorb 0x01 at byte 0, no data) -> PERM (AD) or FIN (message); FIN: done=1 -> IDLE.
//  in_ready = (FSM==ABSORB) && (!out_valid || out_ready).
//  Absorb, enc: S_r ^= data; out = S_r truncated to in_bytes. Dec: out = data ^ S_r; S_r bytes < in_bytes := data.
//  Padding: last beat with in_bytes < RATE/8 XORs 0x01 into byte in_bytes of S_r after absorb;
//  last beat with in_bytes == RATE/8 schedules PADBLK. Non-last beats carry no padding.
//  AD beat: always followed by PERM (ROUNDS_B/UNROLL cycles). AD last (incl. its PADBLK perm) arms domain separation.
//  Domain separation: x4 ^= 64'h8000_0000_0000_0000 exactly once, applied on the cycle the first message beat
//  is accepted, before absorb; also applies when the AD phase was empty.
//  Message non-last beat -> PERM; message last beat -> no perm; FIN (or PADBLK then FIN).
//  Empty message: in_last, in_bytes=0 -> x0 byte0 ^= 0x01, one out beat with out_bytes=0.
//  Every accepted message beat yields exactly one out beat, registered, out_valid the next cycle; held until out_ready.
//  Round constant for round k of p_b (k=0..ROUNDS_B-1): i = 12-ROUNDS_B+k, c = {4'hF-i, i[3:0]} XOR x2[7:0].
//  Round counter width $clog2(ROUNDS_B)+1; saturates at ROUNDS_B/UNROLL, then resets at next perm.
//  Errors (set err, drop beat, FSM -> IDLE, no done): in_bytes > RATE/8; non-last beat with in_bytes != RATE/8;
//  AD beat after any message beat; in_valid in IDLE is ignored (no error).
//  start in any state: reload state, clear err/flags, drop pending out beat (out_valid -> 0) same cycle.
//  Async reset mid-operation: immediate return to reset values, no partial done.
// STRUCTURE
//  ascon_pkg: ASCON_STATE_W=320, lane width 64, DOMSEP_BIT constant, round-constant function, FSM state enum.
//  Sub-module ascon_round (one combinational p_C/p_S/p_L round, input rc); UNROLL instances chained in a generate loop.
//  Pad/byte-mask logic as a package function pad_mask(in_bytes) -> RATE_BITS mask.
// TESTING (compare state_o/out_data against golden Ascon model, e.g. pyascon)
//  RATE 64, state_i=0, start, no AD, msg 1 beat in_last, in_bytes=0 -> one out beat out_bytes=0, x0=64'h1, x4 MSB set, done.
//  RATE 128, 2 full AD beats + msg 5 bytes 01..05 enc -> out_data[127:40]=0, state_o matches model, err=0.
//  Same key/nonce, dec of CT from previous case -> out_data low bytes 01..05; state_o identical to enc run.
//  Full last msg beat (in_bytes=16) -> PADBLK: x0 byte0 ^= 0x01 after absorb, no extra perm, done after out beat.
//  out_ready held low 20 cycles during msg stream -> in_ready low, no beat lost or duplicated, order preserved.
//  AD beat after message beat -> err=1, FSM IDLE, no done; start mid-PERM -> new job result matches model.

Source files
------------

// File: rtl/ascon_pkg.sv
// rtl/ascon_pkg.sv - shared constants, FSM encoding and pad/round-constant helpers for the Ascon absorb engine
package ascon_pkg;

  localparam int ASCON_STATE_W  = 320;
  localparam int LANE_W         = 64;
  localparam int DOMSEP_BIT     = 63;
  localparam int MAX_RATE_BYTES = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_PERM,
    ST_PADBLK,
    ST_FIN
  } fsm_e;

  // p_b round k uses the tail of the p12 constant schedule
  function automatic logic [7:0] round_const(input int rounds, input int k);
    int         i;
    logic [3:0] lo;
    i  = 12 - rounds + k;
    lo = i[3:0];
    return {4'hF - lo, lo};
  endfunction

  function automatic logic [127:0] pad_mask(input logic [4:0] nbytes);
    logic [127:0] m;
    m = '0;
    for (int b = 0; b < MAX_RATE_BYTES; b++)
      if (5'(b) < nbytes) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [127:0] pad_byte(input logic [4:0] nbytes);
    logic [127:0] p;
    p = '0;
    for (int b = 0; b < MAX_RATE_BYTES; b++)
      if (5'(b) == nbytes) p[8*b] = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/ascon_round.sv
// rtl/ascon_round.sv - one combinational Ascon round: constant addition, 5-bit S-box layer, linear diffusion
module ascon_round
  import ascon_pkg::*;
(
  input  logic [ASCON_STATE_W-1:0] s_i,
  input  logic [7:0]               rc,
  output logic [ASCON_STATE_W-1:0] s_o
);

  function automatic logic [LANE_W-1:0] ror(input logic [LANE_W-1:0] x, input int n);
    return (x >> n) | (x << (LANE_W - n));
  endfunction

  logic [LANE_W-1:0] u0, u1, u2, u3, u4;
  logic [LANE_W-1:0] v0, v1, v2, v3, v4;
  logic [LANE_W-1:0] w0, w1, w2, w3, w4;

  always_comb begin
    u0 = s_i[319:256] ^ s_i[63:0];
    u1 = s_i[255:192];
    u2 = s_i[191:128] ^ {56'h0, rc} ^ s_i[255:192];
    u3 = s_i[127:64];
    u4 = s_i[63:0] ^ s_i[127:64];

    v0 = u0 ^ (~u1 & u2);
    v1 = u1 ^ (~u2 & u3);
    v2 = u2 ^ (~u3 & u4);
    v3 = u3 ^ (~u4 & u0);
    v4 = u4 ^ (~u0 & u1);

    w0 = v0 ^ v4;
    w1 = v1 ^ v0;
    w2 = ~v2;
    w3 = v3 ^ v2;
    w4 = v4;

    s_o = {w0 ^ ror(w0, 19) ^ ror(w0, 28),
           w1 ^ ror(w1, 61) ^ ror(w1, 39),
           w2 ^ ror(w2, 1)  ^ ror(w2, 6),
           w3 ^ ror(w3, 10) ^ ror(w3, 17),
           w4 ^ ror(w4, 7)  ^ ror(w4, 41)};
  end

endmodule

// File: rtl/ascon_aead_data_engine.sv
// rtl/ascon_aead_data_engine.sv - streaming AD/message absorb engine between Ascon init and finalization
module ascon_aead_data_engine
  import ascon_pkg::*;
#(
  parameter int RATE_BITS = 128,
  parameter int ROUNDS_B  = 8,
  parameter int UNROLL    = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          mode,
  input  logic [ASCON_STATE_W-1:0]      state_i,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_type,
  input  logic [RATE_BITS-1:0]          in_data,
  input  logic [$clog2(RATE_BITS/8):0]  in_bytes,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [RATE_BITS-1:0]          out_data,
  output logic [$clog2(RATE_BITS/8):0]  out_bytes,
  output logic                          done,
  output logic [ASCON_STATE_W-1:0]      state_o,
  output logic                          err
);

  localparam int RB      = RATE_BITS / 8;
  localparam int BW      = $clog2(RB) + 1;
  localparam int CW      = $clog2(ROUNDS_B) + 1;
  localparam int STEPS   = ROUNDS_B / UNROLL;
  localparam bit BAD_CFG = (ROUNDS_B % UNROLL) != 0;
  localparam logic [CW-1:0] STEPS_C = CW'(STEPS);

  fsm_e                     fsm_q, fsm_d;
  logic [ASCON_STATE_W-1:0] s_q, s_d, state_o_q, state_o_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     pad_pend_q, pad_pend_d, pad_msg_q, pad_msg_d;
  logic                     msg_seen_q, msg_seen_d, mode_q, mode_d, err_q, err_d;
  logic                     out_valid_q, out_valid_d;
  logic [RATE_BITS-1:0]     out_data_q, out_data_d;
  logic [BW-1:0]            out_bytes_q, out_bytes_d;

  // UNROLL rounds per clock, round index continues across clocks
  logic [UNROLL:0][ASCON_STATE_W-1:0] chain;
  assign chain[0] = s_q;
  for (genvar j = 0; j < UNROLL; j++) begin : g_round
    logic [7:0] rc;
    assign rc = round_const(ROUNDS_B, int'(cnt_q) * UNROLL + j);
    ascon_round u_round (
      .s_i (chain[j]),
      .rc  (rc),
      .s_o (chain[j+1])
    );
  end

  logic [4:0]               nb5;
  logic                     full, bad;
  logic [127:0]             rate_full, rate_upd_full, mask_full, padb_full;
  logic [RATE_BITS-1:0]     rate_cur, mask, padv, data_m, xored, rate_new;
  logic [ASCON_STATE_W-1:0] s_absorb;

  // Rate lanes in byte order: x0 holds bytes 0..7, x1 bytes 8..15
  always_comb begin
    nb5       = 5'(in_bytes);
    full      = (in_bytes == BW'(RB));
    bad       = (in_bytes > BW'(RB)) || (!in_last && !full) || (!in_type && msg_seen_q);
    rate_full = {s_q[255:192], s_q[319:256]};
    rate_cur  = rate_full[RATE_BITS-1:0];
    mask_full = pad_mask(nb5);
    padb_full = pad_byte(nb5);
    mask      = mask_full[RATE_BITS-1:0];
    padv      = (in_last && !full) ? padb_full[RATE_BITS-1:0] : '0;
    data_m    = in_data & mask;
    xored     = rate_cur ^ data_m;
    if (in_type && mode_q) rate_new = ((rate_cur & ~mask) | data_m) ^ padv;
    else                   rate_new = xored ^ padv;
    rate_upd_full = rate_full;
    rate_upd_full[RATE_BITS-1:0] = rate_new;
    s_absorb = s_q;
    s_absorb[319:256] = rate_upd_full[63:0];
    s_absorb[255:192] = rate_upd_full[127:64];
    if (in_type && !msg_seen_q) s_absorb[DOMSEP_BIT] = ~s_q[DOMSEP_BIT];
  end

  assign in_ready  = (fsm_q == ST_ABSORB) && (!out_valid_q || out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_bytes = out_bytes_q;
  assign state_o   = state_o_q;
  assign err       = err_q | BAD_CFG;

  always_comb begin
    fsm_d       = fsm_q;
    s_d         = s_q;
    cnt_d       = cnt_q;
    pad_pend_d  = pad_pend_q;
    pad_msg_d   = pad_msg_q;
    msg_seen_d  = msg_seen_q;
    mode_d      = mode_q;
    err_d       = err_q;
    out_valid_d = out_valid_q && !out_ready;
    out_data_d  = out_data_q;
    out_bytes_d = out_bytes_q;
    state_o_d   = state_o_q;
    done        = 1'b0;

    case (fsm_q)
      ST_ABSORB: begin
        if (in_valid && in_ready) begin
          if (bad) begin
            err_d = 1'b1;
            fsm_d = ST_IDLE;
          end else begin
            s_d = s_absorb;
            if (in_type) begin
              msg_seen_d  = 1'b1;
              out_valid_d = 1'b1;
              out_data_d  = xored & mask;
              out_bytes_d = in_bytes;
              if (!in_last) begin
                fsm_d = ST_PERM;
                cnt_d = '0;
              end else if (full) begin
                fsm_d     = ST_PADBLK;
                pad_msg_d = 1'b1;
              end else begin
                fsm_d = ST_FIN;
              end
            end else begin
              fsm_d      = ST_PERM;
              cnt_d      = '0;
              pad_pend_d = in_last && full;
            end
          end
        end
      end
      ST_PERM: begin
        s_d   = chain[UNROLL];
        cnt_d = (cnt_q == STEPS_C) ? cnt_q : cnt_q + 1'b1;
        if (cnt_q == STEPS_C - 1'b1) fsm_d = pad_pend_q ? ST_PADBLK : ST_ABSORB;
      end
      ST_PADBLK: begin
        s_d[256]   = ~s_q[256];
        pad_pend_d = 1'b0;
        cnt_d      = '0;
        fsm_d      = pad_msg_q ? ST_FIN : ST_PERM;
      end
      ST_FIN: begin
        // done waits until the final out beat has left
        if (!out_valid_q || out_ready) begin
          done  = 1'b1;
          fsm_d = ST_IDLE;
        end
      end
      default: fsm_d = ST_IDLE;
    endcase

    if (fsm_d == ST_FIN && fsm_q != ST_FIN) state_o_d = s_d;

    if (start) begin
      fsm_d       = ST_ABSORB;
      s_d         = state_i;
      cnt_d       = '0;
      pad_pend_d  = 1'b0;
      pad_msg_d   = 1'b0;
      msg_seen_d  = 1'b0;
      mode_d      = mode;
      err_d       = 1'b0;
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= ST_IDLE;
      s_q         <= '0;
      cnt_q       <= '0;
      pad_pend_q  <= 1'b0;
      pad_msg_q   <= 1'b0;
      msg_seen_q  <= 1'b0;
      mode_q      <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_bytes_q <= '0;
      state_o_q   <= '0;
    end else begin
      fsm_q       <= fsm_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      pad_pend_q  <= pad_pend_d;
      pad_msg_q   <= pad_msg_d;
      msg_seen_q  <= msg_seen_d;
      mode_q      <= mode_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_bytes_q <= out_bytes_d;
      state_o_q   <= state_o_d;
    end
  end

endmodule

// File: tb/tb_ascon_aead_data_engine.sv
// tb/tb_ascon_aead_data_engine.sv - directed self-checking bench with a table-driven Ascon reference model
module tb_ascon_aead_data_engine;

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, mode = 1'b0;
  logic [319:0] state_i = '0;
  logic         in_valid = 1'b0, in_type = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [127:0] in_data = '0;
  logic [4:0]   in_bytes = '0;
  logic         in_ready, out_valid, done, err;
  logic [127:0] out_data;
  logic [4:0]   out_bytes;
  logic [319:0] state_o;

  int checks = 0, errors = 0, done_cnt = 0;
  logic [127:0] q_data [$];
  logic [4:0]   q_bytes [$];

  localparam logic [4:0] SBOX [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
  localparam logic [7:0] RC [8] = '{8'hb4, 8'ha5, 8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b};

  ascon_aead_data_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .state_i(state_i),
    .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type), .in_data(in_data),
    .in_bytes(in_bytes), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_bytes(out_bytes), .done(done), .state_o(state_o), .err(err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      q_data.push_back(out_data);
      q_bytes.push_back(out_bytes);
    end
    if (done) done_cnt++;
  end

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [319:0] perm(input logic [319:0] s);
    logic [63:0] x [5];
    logic [4:0]  v;
    for (int l = 0; l < 5; l++) x[l] = s[319-64*l -: 64];
    for (int r = 0; r < 8; r++) begin
      x[2][7:0] = x[2][7:0] ^ RC[r];
      for (int b = 0; b < 64; b++) begin
        v = SBOX[{x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]}];
        for (int l = 0; l < 5; l++) x[l][b] = v[4-l];
      end
      x[0] = x[0] ^ ror(x[0], 19) ^ ror(x[0], 28);
      x[1] = x[1] ^ ror(x[1], 61) ^ ror(x[1], 39);
      x[2] = x[2] ^ ror(x[2], 1)  ^ ror(x[2], 6);
      x[3] = x[3] ^ ror(x[3], 10) ^ ror(x[3], 17);
      x[4] = x[4] ^ ror(x[4], 7)  ^ ror(x[4], 41);
    end
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction

  function automatic logic [319:0] xr(input logic [319:0] s, input logic [127:0] r);
    s[319:256] = s[319:256] ^ r[63:0];
    s[255:192] = s[255:192] ^ r[127:64];
    return s;
  endfunction

  function automatic logic [127:0] getr(input logic [319:0] s);
    return {s[255:192], s[319:256]};
  endfunction

  function automatic logic [127:0] bmask(input int n);
    logic [127:0] m;
    m = '0;
    for (int b = 0; b < n; b++) m[8*b +: 8] = 8'hff;
    return m;
  endfunction

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input logic [319:0] s, input logic m);
    state_i = s;
    mode    = m;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic send(input logic t, input logic [127:0] d, input logic [4:0] nb, input logic l);
    int n = 0;
    in_valid = 1'b1; in_type = t; in_data = d; in_bytes = nb; in_last = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("beat_accepted", n < 200, 1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int   n = 0;
    logic seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      seen = done;
      n++;
    end
    check(tag, seen, 1);
  endtask

  initial begin
    logic [319:0] s0, s1, e, s_enc;
    logic [127:0] a1, a2, m1, m2, m3, ct, c1, c2, c3;
    int d0;

    s0 = {64'h0123456789abcdef, 64'hfedcba9876543210, 64'h0f1e2d3c4b5a6978,
          64'h8796a5b4c3d2e1f0, 64'h1122334455667788};
    s1 = {64'hdeadbeefcafef00d, 64'h0011223344556677, 64'h8899aabbccddeeff,
          64'h13579bdf02468ace, 64'hfedcba9876543210};
    a1 = 128'h00112233445566778899aabbccddeeff;
    a2 = 128'h0f0e0d0c0b0a09080706050403020100;
    m1 = 128'h6f6e6d6c6b6a69686766656463626160;
    m2 = 128'ha5a5a5a55a5a5a5a0123456789abcdef;
    m3 = 128'h7766554433221100ffeeddccbbaa9988;

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_state_o", state_o, 0);
    check("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    step();

    // empty message, no AD
    q_data.delete(); q_bytes.delete();
    start_job(320'h0, 1'b0);
    send(1'b1, 128'hdeadbeef00000000cafebabe12345678, 5'd0, 1'b1);
    wait_done("empty_done");
    check("empty_state", state_o, {64'h1, 192'h0, 64'h8000000000000000});
    step();
    check("empty_nbeats", q_data.size(), 1);
    check("empty_out_data", q_data[0], 0);
    check("empty_out_bytes", q_bytes[0], 0);

    // two full AD beats (second last -> pad block) + 5-byte encrypt
    e = perm(xr(s0, a1));
    e = perm(xr(e, a2));
    e = perm(xr(e, 128'h1));
    e[63] = ~e[63];
    e = xr(e, 128'h0504030201);
    ct = getr(e) & bmask(5);
    s_enc = xr(e, 128'h01 << 40);
    q_data.delete(); q_bytes.delete();
    start_job(s0, 1'b0);
    send(1'b0, a1, 5'd16, 1'b0);
    send(1'b0, a2, 5'd16, 1'b1);
    send(1'b1, {88'hffeeddccbbaa9988776655, 40'h0504030201}, 5'd5, 1'b1);
    wait_done("enc_done");
    check("enc_state", state_o, s_enc);
    step();
    check("enc_out_data", q_data[0], ct);
    check("enc_out_upper_zero", q_data[0][127:40], 0);
    check("enc_out_bytes", q_bytes[0], 5);
    check("enc_err", err, 0);

    // decrypt the ciphertext under the same initial state
    q_data.delete(); q_bytes.delete();
    start_job(s0, 1'b1);
    send(1'b0, a1, 5'd16, 1'b0);
    send(1'b0, a2, 5'd16, 1'b1);
    send(1'b1, ct | {88'h5a5a5a5a5a5a5a5a5a5a5a, 40'h0}, 5'd5, 1'b1);
    wait_done("dec_done");
    check("dec_state", state_o, s_enc);
    step();
    check("dec_out_data", q_data[0], 128'h0504030201);

    // abort mid-permutation with a pending out beat, then backpressured full-block job
    e = s1;
    e[63] = ~e[63];
    e = xr(e, m1); c1 = getr(e); e = perm(e);
    e = xr(e, m2); c2 = getr(e); e = perm(e);
    e = xr(e, m3); c3 = getr(e);
    e = xr(e, 128'h1);
    q_data.delete(); q_bytes.delete();
    d0 = done_cnt;
    out_ready = 1'b0;
    start_job(s0, 1'b0);
    send(1'b1, m2, 5'd16, 1'b0);
    step();
    check("abort_pending_beat", out_valid, 1);
    start_job(s1, 1'b0);
    check("abort_drops_beat", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    send(1'b1, m1, 5'd16, 1'b0);
    in_valid = 1'b1; in_type = 1'b1; in_data = m2; in_bytes = 5'd16; in_last = 1'b0;
    repeat (20) step();
    check("bp_in_ready_low", in_ready, 0);
    check("bp_out_valid_held", out_valid, 1);
    check("bp_out_data_held", out_data, c1);
    check("bp_no_beat_yet", q_data.size(), 0);
    out_ready = 1'b1;
    send(1'b1, m2, 5'd16, 1'b0);
    send(1'b1, m3, 5'd16, 1'b1);
    wait_done("full_done");
    check("full_state", state_o, e);
    step();
    check("full_nbeats", q_data.size(), 3);
    check("full_beat0", q_data[0], c1);
    check("full_beat1", q_data[1], c2);
    check("full_beat2", q_data[2], c3);
    check("full_bytes2", q_bytes[2], 16);
    check("full_done_count", done_cnt - d0, 1);

    // AD after message: error, back to idle, no done
    d0 = done_cnt;
    start_job(s0, 1'b0);
    send(1'b1, m1, 5'd16, 1'b0);
    send(1'b0, a1, 5'd16, 1'b0);
    check("ad_after_msg_err", err, 1);
    check("ad_after_msg_idle", in_ready, 0);
    repeat (10) step();
    check("ad_after_msg_no_done", done_cnt - d0, 0);

    // start clears err; short non-last beat and oversized byte count are errors
    start_job(s0, 1'b0);
    check("start_clears_err", err, 0);
    send(1'b0, a1, 5'd3, 1'b0);
    check("short_nonlast_err", err, 1);
    start_job(s0, 1'b0);
    send(1'b1, m1, 5'd17, 1'b1);
    check("oversize_err", err, 1);
    check("oversize_idle", in_ready, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
